hub75_plane_fetch: RTL and testbench
====================================

// Module: hub75_plane_fetch
// PURPOSE
// - Upstream pixel source for the HUB-75 panel driver.
// - Reads RGB pixels from a synchronous frame-buffer read port.
// - Slices one binary-code-modulation bit plane per column.
// - Emits one 6-bit word {r1,g1,b1,r2,g2,b2} per column over a valid/ready stream.
// - Scan order: row 0..ROWS-1 (outer), plane 0..COLOR_BITS-1 LSB first (middle),
//   column 0..WIDTH-1 (inner).
// PARAMETERS
// - WIDTH       64  panel columns; power of 2; COL_BITS = $clog2(WIDTH)
// - HEIGHT      64  panel rows; ROWS = HEIGHT/2 scan rows; ROW_BITS = $clog2(ROWS)
// - COLOR_BITS  8   bits per channel; pixel word is 3*COLOR_BITS, laid out {r,g,b}
// PORTS
// - clock      in   1                    single system clock, rising edge
// - reset      in   1                    synchronous, active-high
// - run        in   1                    start/continue frame scanning
// - mem_rd_en  out  1                    frame-buffer read strobe
// - mem_addr   out  [BANK+]1+ROW_BITS+COL_BITS  read address {bank?, half, row, col}
// - mem_rdata  in   3*COLOR_BITS         read data, valid 1 cycle after mem_rd_en
// - pix_valid  out  1                    output word valid
// - pix_ready  in   1                    consumer accepts the word
// - pix_data   out  6                    {r1,g1,b1,r2,g2,b2}
// - pix_last   out  1                    word is column WIDTH-1 of this row/plane
// - pix_row    out  ROW_BITS             scan row of the word
// - pix_plane  out  $clog2(COLOR_BITS)   bit plane of the word
// - frame_start out 1                    1-cycle pulse on entry to RD_TOP for row0/plane0/col0
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, col/row/plane counters 0, bank 0.
// - Reset mid-operation aborts immediately: pix_valid drops, no partial word completes.
// - States and transitions:
//   - IDLE: go to RD_TOP when run=1.
//   - RD_TOP: mem_rd_en=1, half=0 (top pixel at {0,row,col}); go to RD_BOT.
//   - RD_BOT: mem_rd_en=1, half=1 (bottom pixel at {1,row,col}); register top rdata;
//     go to CAPTURE.
//   - CAPTURE: register bottom rdata; load pix_data, pix_row, pix_plane, pix_last;
//     go to HOLD.
//   - HOLD: pix_valid=1 until pix_valid & pix_ready.
//     - On handshake: advance counters and go to RD_TOP.
//     - Exception: if the accepted word is the frame end (row ROWS-1, plane COLOR_BITS-1,
//       col WIDTH-1) and run=0, go to IDLE.
// - Plane slicing, for plane p: r1=top.r[p], g1=top.g[p], b1=top.b[p]; r2/g2/b2 likewise
//   from bottom.
// - Timing:
//   - Latency: RD_TOP entered at edge k gives pix_valid high from edge k+3.
//   - Throughput: 1 word per 4 cycles with pix_ready held high.
// - Counter wrap:
//   - col wraps WIDTH-1 -> 0 and carries into plane.
//   - plane wraps COLOR_BITS-1 -> 0 and carries into row.
//   - row wraps ROWS-1 -> 0 (frame end).
// - Output stability: pix_data, pix_row, pix_plane, pix_last are stable while
//   pix_valid=1 and pix_ready=0.
// - mem_rd_en is 0 outside RD_TOP/RD_BOT; mem_addr holds its last value when not reading.
// - run only matters in IDLE and at frame end; deasserting run mid-frame never truncates
//   the frame.
// CONFIGURATION
// - HUB75_DOUBLE_BUFFER_EN defined:
//   - Adds input swap_req (1 bit) and outputs disp_bank (1 bit) and swap_ack (1 bit).
//   - mem_addr gains MSB = disp_bank.
//   - A swap_req pulse sets a pending flag; a second request while pending is absorbed.
//   - Pending flag applied at the frame-end handshake: disp_bank toggles and swap_ack
//     pulses for 1 cycle that same cycle.
//   - swap_req on the frame-end handshake cycle is applied immediately.
//   - Reset clears pending, disp_bank, swap_ack.
// - HUB75_DOUBLE_BUFFER_EN undefined: those ports absent; mem_addr has no bank bit.
// TESTING
// - Reset, run=1, pix_ready=1, then mem_rdata=24'hFF0000 at top, 24'h0000FF at bottom
//   -> first word at edge 3 after RD_TOP: pix_data=6'b100_001, row0, plane0, pix_last=0.
// - Memory model rdata=address-derived pattern, full frame with pix_ready=1
//   -> 32*8*64=16384 words in scan order; pix_last on every 64th word;
//      frame_start once per frame.
// - pix_ready randomly low (~50%) -> no dropped or duplicated word; outputs stable while
//   stalled.
// - run deasserted at row 10 -> frame finishes through row 31 plane 7 col 63,
//   then IDLE with pix_valid=0.
// - reset asserted in HOLD with pix_valid=1 -> next cycle pix_valid=0, counters 0;
//   next frame restarts at row0/col0.
// - HUB75_DOUBLE_BUFFER_EN: swap_req mid-frame -> disp_bank toggles and swap_ack pulses
//   exactly on the frame-end handshake; next mem_addr MSB=1.

Source files
------------

// File: rtl/hub75_plane_fetch.sv
// HUB-75 bit-plane fetch: reads top/bottom pixel pairs from the frame buffer and streams
// one 6-bit BCM slice {r1,g1,b1,r2,g2,b2} per column. Optional macro: HUB75_DOUBLE_BUFFER_EN.
module hub75_plane_fetch #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int COLOR_BITS = 8,
    localparam int COL_BITS   = $clog2(WIDTH),
    localparam int ROWS       = HEIGHT / 2,
    localparam int ROW_BITS   = $clog2(ROWS),
    localparam int PLANE_BITS = $clog2(COLOR_BITS),
    localparam int PIX_W      = 3 * COLOR_BITS,
`ifdef HUB75_DOUBLE_BUFFER_EN
    localparam int BANK_BITS  = 1,
`else
    localparam int BANK_BITS  = 0,
`endif
    localparam int ADDR_W     = BANK_BITS + 1 + ROW_BITS + COL_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
`ifdef HUB75_DOUBLE_BUFFER_EN
    input  logic                  swap_req,
    output logic                  disp_bank,
    output logic                  swap_ack,
`endif
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [PIX_W-1:0]      mem_rdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [5:0]            pix_data,
    output logic                  pix_last,
    output logic [ROW_BITS-1:0]   pix_row,
    output logic [PLANE_BITS-1:0] pix_plane,
    output logic                  frame_start
);

    typedef enum logic [2:0] {
        IDLE,
        RD_TOP,
        RD_BOT,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [COL_BITS-1:0]   COL_MAX   = COL_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0]   ROW_MAX   = ROW_BITS'(ROWS - 1);
    localparam logic [PLANE_BITS-1:0] PLANE_MAX = PLANE_BITS'(COLOR_BITS - 1);

    state_t                state_reg;
    logic [COL_BITS-1:0]   col_reg;
    logic [COL_BITS-1:0]   col_next;
    logic [ROW_BITS-1:0]   row_reg;
    logic [ROW_BITS-1:0]   row_next;
    logic [PLANE_BITS-1:0] plane_reg;
    logic [PLANE_BITS-1:0] plane_next;
    logic                  frame_end;
    logic [PIX_W-1:0]      top_reg;

    logic                  mem_rd_en_reg;
    logic [ADDR_W-1:0]     mem_addr_reg;
    logic                  pix_valid_reg;
    logic [5:0]            pix_data_reg;
    logic                  pix_last_reg;
    logic [ROW_BITS-1:0]   pix_row_reg;
    logic [PLANE_BITS-1:0] pix_plane_reg;
    logic                  frame_start_reg;

    logic                  handshake;
    logic [ROW_BITS-1:0]   rd_row;
    logic [COL_BITS-1:0]   rd_col;
    logic [ADDR_W-1:0]     top_addr;
    logic [ADDR_W-1:0]     bot_addr;
    logic [2:0]            top_bits;
    logic [2:0]            bot_bits;

    assign mem_rd_en   = mem_rd_en_reg;
    assign mem_addr    = mem_addr_reg;
    assign pix_valid   = pix_valid_reg;
    assign pix_data    = pix_data_reg;
    assign pix_last    = pix_last_reg;
    assign pix_row     = pix_row_reg;
    assign pix_plane   = pix_plane_reg;
    assign frame_start = frame_start_reg;

    assign handshake = (state_reg == HOLD) && pix_valid_reg && pix_ready;

    // Scan position after the current word: col is innermost, then plane, then row.
    always_comb begin
        col_next   = col_reg;
        plane_next = plane_reg;
        row_next   = row_reg;
        frame_end  = 1'b0;
        if (col_reg == COL_MAX) begin
            col_next = '0;
            if (plane_reg == PLANE_MAX) begin
                plane_next = '0;
                if (row_reg == ROW_MAX) begin
                    row_next  = '0;
                    frame_end = 1'b1;
                end else begin
                    row_next = row_reg + 1'b1;
                end
            end else begin
                plane_next = plane_reg + 1'b1;
            end
        end else begin
            col_next = col_reg + 1'b1;
        end
    end

    // The top read issued from HOLD already targets the advanced position.
    assign rd_row = (state_reg == HOLD) ? row_next : row_reg;
    assign rd_col = (state_reg == HOLD) ? col_next : col_reg;

    // Channel index 2/1/0 is r/g/b, so {top_bits, bot_bits} is {r1,g1,b1,r2,g2,b2}.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slice
            logic [COLOR_BITS-1:0] top_ch;
            logic [COLOR_BITS-1:0] bot_ch;
            assign top_ch       = top_reg[gi*COLOR_BITS +: COLOR_BITS];
            assign bot_ch       = mem_rdata[gi*COLOR_BITS +: COLOR_BITS];
            assign top_bits[gi] = top_ch[plane_reg];
            assign bot_bits[gi] = bot_ch[plane_reg];
        end
    endgenerate

`ifdef HUB75_DOUBLE_BUFFER_EN
    logic bank_reg;
    logic bank_next;
    logic pending_reg;
    logic pending_next;
    logic swap_ack_reg;
    logic swap_fire;

    // A request arriving on the frame-end handshake itself takes effect immediately.
    always_comb begin
        bank_next    = bank_reg;
        pending_next = pending_reg | swap_req;
        swap_fire    = 1'b0;
        if (handshake && frame_end && (pending_reg || swap_req)) begin
            bank_next    = ~bank_reg;
            pending_next = 1'b0;
            swap_fire    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank_reg     <= 1'b0;
            pending_reg  <= 1'b0;
            swap_ack_reg <= 1'b0;
        end else begin
            bank_reg     <= bank_next;
            pending_reg  <= pending_next;
            swap_ack_reg <= swap_fire;
        end
    end

    assign disp_bank = bank_reg;
    assign swap_ack  = swap_ack_reg;
    assign top_addr  = {bank_next, 1'b0, rd_row, rd_col};
    assign bot_addr  = {bank_reg, 1'b1, row_reg, col_reg};
`else
    assign top_addr  = {1'b0, rd_row, rd_col};
    assign bot_addr  = {1'b1, row_reg, col_reg};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            col_reg         <= '0;
            row_reg         <= '0;
            plane_reg       <= '0;
            top_reg         <= '0;
            mem_rd_en_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            pix_valid_reg   <= 1'b0;
            pix_data_reg    <= '0;
            pix_last_reg    <= 1'b0;
            pix_row_reg     <= '0;
            pix_plane_reg   <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Counters are always zero here (after reset or a completed frame).
                    if (run) begin
                        state_reg       <= RD_TOP;
                        mem_rd_en_reg   <= 1'b1;
                        mem_addr_reg    <= top_addr;
                        frame_start_reg <= 1'b1;
                    end
                end
                RD_TOP: begin
                    state_reg    <= RD_BOT;
                    mem_addr_reg <= bot_addr;
                end
                RD_BOT: begin
                    state_reg     <= CAPTURE;
                    mem_rd_en_reg <= 1'b0;
                    top_reg       <= mem_rdata;
                end
                CAPTURE: begin
                    state_reg     <= HOLD;
                    pix_valid_reg <= 1'b1;
                    pix_data_reg  <= {top_bits, bot_bits};
                    pix_row_reg   <= row_reg;
                    pix_plane_reg <= plane_reg;
                    pix_last_reg  <= (col_reg == COL_MAX);
                end
                HOLD: begin
                    if (handshake) begin
                        pix_valid_reg <= 1'b0;
                        col_reg       <= col_next;
                        row_reg       <= row_next;
                        plane_reg     <= plane_next;
                        if (frame_end && !run) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg       <= RD_TOP;
                            mem_rd_en_reg   <= 1'b1;
                            mem_addr_reg    <= top_addr;
                            frame_start_reg <= frame_end;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_plane_fetch.sv
// Scoreboard bench for hub75_plane_fetch on a reduced 16x32 panel, 8 colour bits.
module tb_hub75_plane_fetch;

    localparam int W    = 16;
    localparam int H    = 32;
    localparam int CB   = 8;
    localparam int ROWS = H / 2;
    localparam int RB   = $clog2(ROWS);
    localparam int COLB = $clog2(W);
    localparam int PB   = $clog2(CB);
`ifdef HUB75_DOUBLE_BUFFER_EN
    localparam int AW   = 2 + RB + COLB;
`else
    localparam int AW   = 1 + RB + COLB;
`endif
    localparam int WPR  = CB * W;
    localparam int NW   = ROWS * WPR;

    typedef struct packed {
        logic [5:0]    data;
        logic [RB-1:0] row;
        logic [PB-1:0] plane;
        logic          last;
    } word_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          pix_ready = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rdata = '0;
    logic          pix_valid;
    logic [5:0]    pix_data;
    logic          pix_last;
    logic [RB-1:0] pix_row;
    logic [PB-1:0] pix_plane;
    logic          frame_start;
`ifdef HUB75_DOUBLE_BUFFER_EN
    logic          swap_req = 1'b0;
    logic          disp_bank;
    logic          swap_ack;
`endif

    int    tests_run = 0;
    int    tests_failed = 0;
    logic  mem_fixed = 1'b0;
    word_t exp_q[$];

    hub75_plane_fetch #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
`ifdef HUB75_DOUBLE_BUFFER_EN
        .swap_req    (swap_req),
        .disp_bank   (disp_bank),
        .swap_ack    (swap_ack),
`endif
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .pix_row     (pix_row),
        .pix_plane   (pix_plane),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] pat(input int a);
        logic [31:0] h;
        h = (32'(a) + 32'h0123_4567) * 32'h9E37_79B1;
        h = h ^ (h >> 13);
        return h[23:0];
    endfunction

    // Synchronous read port: data appears the cycle after the strobe.
    always @(posedge clock) begin
        if (mem_rd_en) begin
            if (mem_fixed)
                mem_rdata <= (((int'(mem_addr) / (ROWS * W)) % 2) == 1) ? 24'h0000FF : 24'hFF0000;
            else
                mem_rdata <= pat(int'(mem_addr));
        end
    end

    function automatic word_t exp_word(input int idx, input int bank);
        int r, p, c;
        logic [23:0] t, b;
        word_t w;
        r = idx / WPR;
        p = (idx / W) % CB;
        c = idx % W;
        t = pat(bank * 2 * ROWS * W + r * W + c);
        b = pat(bank * 2 * ROWS * W + ROWS * W + r * W + c);
        w.data  = {t[2*CB+p], t[CB+p], t[p], b[2*CB+p], b[CB+p], b[p]};
        w.row   = RB'(r);
        w.plane = PB'(p);
        w.last  = (c == W - 1);
        return w;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        run = 1'b0;
        pix_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b1;
        pix_ready = 1'b1;
        repeat (3) step();
        @(negedge clock);
        tests_run++;
        if (pix_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pix_valid: got %b expected 0", pix_valid);
        end
        tests_run++;
        if (mem_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_rd_en: got %b expected 0", mem_rd_en);
        end
        tests_run++;
        if (frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        tests_run++;
        if ({mem_addr, pix_data, pix_row, pix_plane, pix_last} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got addr=%h data=%b row=%0d plane=%0d last=%b expected all 0",
                     mem_addr, pix_data, pix_row, pix_plane, pix_last);
        end
        step();
        reset = 1'b0;
        run = 1'b0;
        repeat (4) step();
        tests_run++;
        if ({mem_rd_en, pix_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_without_run: got rd_en=%b valid=%b expected 0 0", mem_rd_en, pix_valid);
        end
    endtask

    task automatic test_first_word();
        mem_fixed = 1'b1;
        run = 1'b1;
        pix_ready = 1'b1;
        step();
        tests_run++;
        if ({frame_start, mem_rd_en, mem_addr} !== {1'b1, 1'b1, AW'(0)}) begin
            tests_failed++;
            $display("FAIL first_rd_top: got fs=%b rd_en=%b addr=%h expected 1 1 0", frame_start, mem_rd_en, mem_addr);
        end
        step();
        tests_run++;
        if ({mem_rd_en, mem_addr} !== {1'b1, AW'(ROWS * W)}) begin
            tests_failed++;
            $display("FAIL first_rd_bot: got rd_en=%b addr=%h expected 1 %h", mem_rd_en, mem_addr, AW'(ROWS * W));
        end
        step();
        tests_run++;
        if (pix_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_early_valid: got %b expected 0 at edge k+2", pix_valid);
        end
        step();
        tests_run++;
        if ({pix_valid, pix_data, pix_row, pix_plane, pix_last} !== {1'b1, 6'b100_001, RB'(0), PB'(0), 1'b0}) begin
            tests_failed++;
            $display("FAIL first_word: got valid=%b data=%b row=%0d plane=%0d last=%b expected 1 100001 0 0 0",
                     pix_valid, pix_data, pix_row, pix_plane, pix_last);
        end
        step();
        tests_run++;
        if ({pix_valid, mem_rd_en, mem_addr, frame_start} !== {1'b0, 1'b1, AW'(1), 1'b0}) begin
            tests_failed++;
            $display("FAIL second_rd_top: got valid=%b rd_en=%b addr=%h fs=%b expected 0 1 1 0",
                     pix_valid, mem_rd_en, mem_addr, frame_start);
        end
        repeat (3) step();
        tests_run++;
        if (pix_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL throughput: got valid=%b expected 1 four cycles after first word", pix_valid);
        end
        mem_fixed = 1'b0;
    endtask

    task automatic test_full_frame();
        int words, fs, lasts, bad_rd;
        word_t g, e;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back(exp_word(i, 0));
        run = 1'b1;
        pix_ready = 1'b1;
        words = 0; fs = 0; lasts = 0; bad_rd = 0;
        for (int cyc = 0; cyc < NW * 4 + 64 && words < NW; cyc++) begin
            @(negedge clock);
            if (frame_start) fs++;
            if (pix_valid && mem_rd_en) bad_rd++;
            if (pix_valid && pix_ready) begin
                g = {pix_data, pix_row, pix_plane, pix_last};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL full_frame word %0d: got %b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                             words, g.data, g.row, g.plane, g.last, e.data, e.row, e.plane, e.last);
                end
                if (pix_last) lasts++;
                words++;
            end
            if (words < NW) step();
        end
        tests_run++;
        if (words != NW) begin
            tests_failed++;
            $display("FAIL full_frame_count: got %0d words expected %0d", words, NW);
        end
        tests_run++;
        if (fs != 1) begin
            tests_failed++;
            $display("FAIL full_frame_start: got %0d pulses expected 1", fs);
        end
        tests_run++;
        if (lasts != ROWS * CB) begin
            tests_failed++;
            $display("FAIL full_frame_last: got %0d expected %0d", lasts, ROWS * CB);
        end
        tests_run++;
        if (bad_rd != 0) begin
            tests_failed++;
            $display("FAIL rd_en_while_valid: got %0d cycles expected 0", bad_rd);
        end
        step();
        tests_run++;
        if ({frame_start, mem_rd_en, mem_addr} !== {1'b1, 1'b1, AW'(0)}) begin
            tests_failed++;
            $display("FAIL frame_wrap: got fs=%b rd_en=%b addr=%h expected 1 1 0", frame_start, mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_stall();
        localparam int NS = 300;
        int words;
        logic prev_stall;
        logic [$bits(word_t):0] cur, prev;
        word_t g, e;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < NS; i++) exp_q.push_back(exp_word(i, 0));
        run = 1'b1;
        pix_ready = 1'($urandom_range(0, 1));
        words = 0;
        prev_stall = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < NS * 16 + 64 && words < NS; cyc++) begin
            @(negedge clock);
            cur = {pix_valid, pix_data, pix_row, pix_plane, pix_last};
            if (prev_stall) begin
                tests_run++;
                if (cur !== prev) begin
                    tests_failed++;
                    $display("FAIL stall_stable at word %0d: got %h expected %h", words, cur, prev);
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev = cur;
            if (pix_valid && pix_ready) begin
                g = {pix_data, pix_row, pix_plane, pix_last};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL stall word %0d: got %b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                             words, g.data, g.row, g.plane, g.last, e.data, e.row, e.plane, e.last);
                end
                words++;
            end
            if (words < NS) begin
                step();
                pix_ready = 1'($urandom_range(0, 1));
            end
        end
        tests_run++;
        if (words != NS) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d words expected %0d", words, NS);
        end
    endtask

    task automatic test_run_stop();
        int words, fs, active;
        word_t g, e;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back(exp_word(i, 0));
        run = 1'b1;
        pix_ready = 1'b1;
        words = 0; fs = 0; active = 0;
        for (int cyc = 0; cyc < NW * 4 + 64 && words < NW; cyc++) begin
            @(negedge clock);
            if (frame_start) fs++;
            if (pix_valid && pix_ready) begin
                g = {pix_data, pix_row, pix_plane, pix_last};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL run_stop word %0d: got %b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                             words, g.data, g.row, g.plane, g.last, e.data, e.row, e.plane, e.last);
                end
                words++;
            end
            if (words < NW) begin
                step();
                if (words >= 10 * WPR) run = 1'b0;
            end
        end
        tests_run++;
        if (words != NW) begin
            tests_failed++;
            $display("FAIL run_stop_count: got %0d words expected %0d", words, NW);
        end
        repeat (8) begin
            step();
            @(negedge clock);
            if (pix_valid || mem_rd_en || frame_start) active++;
        end
        tests_run++;
        if (active != 0) begin
            tests_failed++;
            $display("FAIL run_stop_idle: got %0d active cycles expected 0", active);
        end
        tests_run++;
        if (fs != 1) begin
            tests_failed++;
            $display("FAIL run_stop_frame_start: got %0d pulses expected 1", fs);
        end
    endtask

    task automatic test_reset_hold();
        int words, fs;
        logic seen;
        word_t g, e;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(i, 0));
        run = 1'b1;
        pix_ready = 1'b1;
        words = 0;
        for (int cyc = 0; cyc < 64 && words < 3; cyc++) begin
            @(negedge clock);
            if (pix_valid && pix_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                g = {pix_data, pix_row, pix_plane, pix_last};
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL hold_pre word %0d: got %b expected %b", words, g.data, e.data);
                end
                words++;
            end
            if (words < 3) step();
        end
        step();
        pix_ready = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clock);
            seen = pix_valid;
            if (!seen) step();
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        g = {pix_data, pix_row, pix_plane, pix_last};
        tests_run++;
        if (!seen || g !== e) begin
            tests_failed++;
            $display("FAIL hold_word: got valid=%b data=%b expected valid=1 data=%b", seen, g.data, e.data);
        end
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if ({pix_valid, mem_rd_en, pix_data, pix_row, pix_plane} !== '0) begin
            tests_failed++;
            $display("FAIL reset_in_hold: got valid=%b rd_en=%b data=%b row=%0d plane=%0d expected all 0",
                     pix_valid, mem_rd_en, pix_data, pix_row, pix_plane);
        end
        reset = 1'b0;
        pix_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(exp_word(0, 0));
        exp_q.push_back(exp_word(1, 0));
        words = 0; fs = 0;
        for (int cyc = 0; cyc < 64 && words < 2; cyc++) begin
            @(negedge clock);
            if (frame_start) fs++;
            if (pix_valid && pix_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                g = {pix_data, pix_row, pix_plane, pix_last};
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL restart word %0d: got %b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                             words, g.data, g.row, g.plane, g.last, e.data, e.row, e.plane, e.last);
                end
                words++;
            end
            if (words < 2) step();
        end
        tests_run++;
        if (words != 2 || fs != 1) begin
            tests_failed++;
            $display("FAIL restart: got %0d words %0d pulses expected 2 words 1 pulse", words, fs);
        end
    endtask

`ifdef HUB75_DOUBLE_BUFFER_EN
    task automatic test_swap();
        int words, acks, ack_words, early;
        logic sent1, sent2, ack_msb;
        word_t g, e;
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back(exp_word(i, 0));
        exp_q.push_back(exp_word(0, 1));
        run = 1'b1;
        pix_ready = 1'b1;
        words = 0; acks = 0; ack_words = -1; early = 0;
        sent1 = 1'b0; sent2 = 1'b0; ack_msb = 1'b0;
        for (int cyc = 0; cyc < (NW + 2) * 4 + 64 && words < NW + 1; cyc++) begin
            @(negedge clock);
            if (words < NW && disp_bank) early++;
            if (swap_ack) begin
                acks++;
                ack_words = words;
                ack_msb = mem_addr[AW-1];
            end
            if (pix_valid && pix_ready) begin
                g = {pix_data, pix_row, pix_plane, pix_last};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                tests_run++;
                if (g !== e) begin
                    tests_failed++;
                    $display("FAIL swap word %0d: got %b expected %b", words, g.data, e.data);
                end
                words++;
            end
            if (words < NW + 1) begin
                step();
                if (words >= 100 && !sent1) begin
                    swap_req = 1'b1;
                    sent1 = 1'b1;
                end else if (words >= 200 && !sent2) begin
                    swap_req = 1'b1;
                    sent2 = 1'b1;
                end else begin
                    swap_req = 1'b0;
                end
            end
        end
        tests_run++;
        if (acks != 1 || ack_words != NW) begin
            tests_failed++;
            $display("FAIL swap_ack: got %0d pulses at word %0d expected 1 at word %0d", acks, ack_words, NW);
        end
        tests_run++;
        if (early != 0 || disp_bank !== 1'b1 || ack_msb !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_bank: got early=%0d bank=%b addr_msb=%b expected 0 1 1", early, disp_bank, ack_msb);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_word();
        test_full_frame();
        test_stall();
        test_run_stop();
        test_reset_hold();
`ifdef HUB75_DOUBLE_BUFFER_EN
        test_swap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
